// File: rtl/swan_pkg.sv
// Shared parameters and FSM state type for the key-schedule preparation blocks.
package swan_pkg;

    localparam int          BLOCK_SIZE = 64;
    localparam int          SIDE_SIZE  = BLOCK_SIZE / 2;
    localparam int          KEY_SIZE   = 256;
    localparam int          PD         = 24;
    localparam logic [31:0] DELTA0     = 32'h9e3779b9;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/enc_key_step_256.sv
// One forward key-schedule step: advance delta, rotate key left by PD, add the new delta
// into the least-significant word. Bit 0 of the key is its MSB.
module enc_key_step_256 #(
    parameter int                   KEY_SIZE  = swan_pkg::KEY_SIZE,
    parameter int                   SIDE_SIZE = swan_pkg::SIDE_SIZE,
    parameter int                   PD        = swan_pkg::PD,
    parameter logic [SIDE_SIZE-1:0] DELTA0    = swan_pkg::DELTA0
) (
    input  logic [0:KEY_SIZE-1]  key,
    input  logic [SIDE_SIZE-1:0] delta,
    output logic [0:KEY_SIZE-1]  next_key,
    output logic [SIDE_SIZE-1:0] next_delta
);

    logic [0:KEY_SIZE-1] rot;

    always_comb begin
        next_delta = delta + DELTA0;
        rot        = {key[PD:KEY_SIZE-1], key[0:PD-1]};
        next_key   = {rot[0:KEY_SIZE-SIDE_SIZE-1],
                      rot[KEY_SIZE-SIDE_SIZE:KEY_SIZE-1] + next_delta};
    end

endmodule

// File: rtl/dec_key_prep_256.sv
// Runs the forward key schedule ROUNDS times from a master key so the decryption
// schedule can start from the final (key, delta) state and walk it backwards.
module dec_key_prep_256 #(
    parameter int          BLOCK_SIZE = swan_pkg::BLOCK_SIZE,
    parameter int          KEY_SIZE   = swan_pkg::KEY_SIZE,
    parameter int          ROUNDS     = 64,
    parameter int          PD         = swan_pkg::PD,
    parameter logic [31:0] DELTA0     = swan_pkg::DELTA0,
    localparam int         SIDE_SIZE  = BLOCK_SIZE / 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [0:KEY_SIZE-1]  in_key,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [0:KEY_SIZE-1]  out_key,
    output logic [SIDE_SIZE-1:0] out_delta
);

    import swan_pkg::*;

    localparam int CW = $clog2(ROUNDS + 1);

    state_t               state, state_n;
    logic [0:KEY_SIZE-1]  key_q;
    logic [SIDE_SIZE-1:0] delta_q;
    logic [CW-1:0]        cnt;
    logic [0:KEY_SIZE-1]  step_key;
    logic [SIDE_SIZE-1:0] step_delta;

    enc_key_step_256 #(
        .KEY_SIZE  (KEY_SIZE),
        .SIDE_SIZE (SIDE_SIZE),
        .PD        (PD),
        .DELTA0    (DELTA0[SIDE_SIZE-1:0])
    ) u_step (
        .key        (key_q),
        .delta      (delta_q),
        .next_key   (step_key),
        .next_delta (step_delta)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            key_q   <= '0;
            delta_q <= '0;
            cnt     <= '0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: if (in_valid) begin
                    key_q   <= in_key;
                    delta_q <= '0;
                    cnt     <= '0;
                end
                RUN: begin
                    key_q   <= step_key;
                    delta_q <= step_delta;
                    cnt     <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    // The step that brings cnt to ROUNDS happens on the same edge that enters DONE.
    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_n = RUN;
            end
            RUN: if (cnt == CW'(ROUNDS - 1)) state_n = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign out_key   = out_valid ? key_q   : '0;
    assign out_delta = out_valid ? delta_q : '0;

endmodule

// File: tb/tb_dec_key_prep_256.sv
// Randomized self-checking bench: three instances (ROUNDS = 1, 2, 64) against a
// numeric model of the forward schedule and its inverse.
module tb_dec_key_prep_256;

    localparam logic [31:0] DELTA = 32'h9e3779b9;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         iv   [3];
    logic         ir   [3];
    logic         ov   [3];
    logic         ordy [3];
    logic [255:0] ik   [3];
    logic [255:0] ok   [3];
    logic [31:0]  od   [3];

    int tests = 0;
    int fails = 0;
    int rounds_of [3] = '{1, 2, 64};

    always #5 clk = ~clk;

    dec_key_prep_256 #(.ROUNDS(1)) u_r1 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_key(ik[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_key(ok[0]), .out_delta(od[0]));
    dec_key_prep_256 #(.ROUNDS(2)) u_r2 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_key(ik[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_key(ok[1]), .out_delta(od[1]));
    dec_key_prep_256 #(.ROUNDS(64)) u_r64 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_key(ik[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .out_key(ok[2]), .out_delta(od[2]));

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] rand_key();
        logic [255:0] k;
        for (int i = 0; i < 8; i++) k[i*32 +: 32] = $urandom;
        return k;
    endfunction

    // Forward schedule as numbers: value rotates left, delta added into the low word.
    task automatic model_fwd(input logic [255:0] k0, input int n,
                             output logic [255:0] k, output logic [31:0] d);
        k = k0;
        d = '0;
        for (int i = 0; i < n; i++) begin
            d = d + DELTA;
            k = {k[231:0], k[255:232]};
            k[31:0] = k[31:0] + d;
        end
    endtask

    task automatic model_inv(input logic [255:0] k0, input logic [31:0] d0, input int n,
                             output logic [255:0] k, output logic [31:0] d);
        k = k0;
        d = d0;
        for (int i = 0; i < n; i++) begin
            k[31:0] = k[31:0] - d;
            k = {k[23:0], k[255:24]};
            d = d - DELTA;
        end
    endtask

    task automatic accept(input int u, input logic [255:0] k);
        @(negedge clk);
        ik[u] = k;
        iv[u] = 1'b1;
        check_eq("accept_ready", ir[u], 1);
        @(posedge clk);
        #1;
        iv[u] = 1'b0;
        ik[u] = rand_key();
    endtask

    task automatic wait_done(input int u, output int lat);
        lat = 1;
        while (!ov[u] && lat < 300) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_out(input int u);
        @(negedge clk);
        ordy[u] = 1'b1;
        @(posedge clk);
        #1;
        ordy[u] = 1'b0;
        check_eq("idle_ready", ir[u], 1);
        check_eq("idle_key0", ok[u], 0);
    endtask

    task automatic run_check(input int u, input logic [255:0] k);
        int lat;
        logic [255:0] ek, bk;
        logic [31:0] ed, bd;
        accept(u, k);
        wait_done(u, lat);
        check_eq("latency", lat, rounds_of[u] + 1);
        model_fwd(k, rounds_of[u], ek, ed);
        check_eq("out_key", ok[u], ek);
        check_eq("out_delta", od[u], ed);
        model_inv(ok[u], od[u], rounds_of[u], bk, bd);
        check_eq("inv_key", bk, k);
        check_eq("inv_delta", bd, 0);
        release_out(u);
    endtask

    initial begin
        int lat;
        logic [255:0] k, ek, hk;
        logic [31:0] ed, hd;
        for (int u = 0; u < 3; u++) begin
            iv[u] = 1'b0; ordy[u] = 1'b0; ik[u] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int u = 0; u < 3; u++) begin
            check_eq("rst_ready", ir[u], 1);
            check_eq("rst_valid", ov[u], 0);
            check_eq("rst_key", ok[u], 0);
            check_eq("rst_delta", od[u], 0);
        end

        // Known-answer vectors from an all-zero key.
        accept(0, '0);
        wait_done(0, lat);
        check_eq("r1_latency", lat, 2);
        check_eq("r1_key", ok[0], 256'h9e3779b9);
        check_eq("r1_delta", od[0], 32'h9e3779b9);
        release_out(0);
        accept(1, '0);
        wait_done(1, lat);
        check_eq("r2_latency", lat, 3);
        check_eq("r2_key", ok[1], 256'h9e3779f56ef372);
        check_eq("r2_delta", od[1], 32'h3c6ef372);
        release_out(1);

        for (int n = 0; n < 4; n++)
            for (int u = 0; u < 3; u++) run_check(u, rand_key());

        // Hold DONE with out_ready low while in_valid toggles.
        k = rand_key();
        accept(2, k);
        wait_done(2, lat);
        check_eq("hold_latency", lat, 65);
        model_fwd(k, 64, ek, ed);
        hk = ok[2];
        hd = od[2];
        check_eq("hold_key_model", hk, ek);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            iv[2] = (i % 3 == 0);
            ik[2] = rand_key();
            check_eq("hold_valid", ov[2], 1);
            check_eq("hold_ready", ir[2], 0);
            check_eq("hold_key", ok[2], hk);
            check_eq("hold_delta", od[2], hd);
        end
        k = rand_key();
        @(negedge clk);
        iv[2] = 1'b1;
        ik[2] = k;
        ordy[2] = 1'b1;
        @(posedge clk);
        #1;
        ordy[2] = 1'b0;
        check_eq("bubble_ready", ir[2], 1);
        check_eq("bubble_valid", ov[2], 0);
        check_eq("bubble_key", ok[2], 0);
        @(posedge clk);
        #1;
        iv[2] = 1'b0;
        check_eq("bubble_accepted", ir[2], 0);
        wait_done(2, lat);
        check_eq("bubble_latency", lat, 65);
        model_fwd(k, 64, ek, ed);
        check_eq("bubble_out_key", ok[2], ek);
        check_eq("bubble_out_delta", od[2], ed);
        release_out(2);

        // Reset in the middle of RUN discards the computation.
        accept(2, rand_key());
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("midrst_ready", ir[2], 1);
        check_eq("midrst_valid", ov[2], 0);
        check_eq("midrst_key", ok[2], 0);
        check_eq("midrst_delta", od[2], 0);
        repeat (70) @(posedge clk);
        #1;
        check_eq("midrst_no_result", ov[2], 0);
        run_check(2, rand_key());

        // Reset and in_valid on the same edge: nothing accepted.
        @(negedge clk);
        rst = 1'b1;
        iv[2] = 1'b1;
        ik[2] = rand_key();
        @(posedge clk);
        #1;
        rst = 1'b0;
        iv[2] = 1'b0;
        check_eq("rstvalid_ready", ir[2], 1);
        @(posedge clk);
        #1;
        check_eq("rstvalid_still_idle", ir[2], 1);
        check_eq("rstvalid_valid", ov[2], 0);
        run_check(2, rand_key());

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1);
    end

endmodule
